// File: rtl/mac_acc.sv
// Sums i_acc_len consecutive products into a result; result valid one cycle after the last product edge.
// Input never stalls; a completion while the output register is full and not accepted is dropped (sticky o_acc_drop). Saturation: MAC_ACC_SAT_EN.
module mac_acc #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CNT_WIDTH-1:0] i_acc_len,
  input  logic                 i_acc_clr,
  input  logic [IN_WIDTH-1:0]  i_prod_val,
  input  logic                 i_prod_valid,
  output logic [ACC_WIDTH-1:0] o_acc_val,
  output logic                 o_acc_valid,
  input  logic                 i_acc_ready,
  output logic                 o_acc_sat,
  output logic                 o_acc_busy,
  output logic                 o_acc_drop
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH-1:0] out_val_q, out_val_d;
  logic                 out_vld_q, out_vld_d;
  logic                 out_sat_q, out_sat_d;
  logic                 drop_q, drop_d;

  logic                 accept;
  logic                 done;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [CNT_WIDTH-1:0] lim;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sat_d     = sat_q;
    out_val_d = out_val_q;
    out_vld_d = out_vld_q;
    out_sat_d = out_sat_q;
    drop_d    = drop_q;
    done      = 1'b0;

    accept  = out_vld_q & i_acc_ready;
    len_eff = (i_acc_len == '0) ? CNT_WIDTH'(1) : i_acc_len;
    // The first product of a result starts from zero and uses the freshly sampled length.
    base    = (state_q == IDLE) ? '0 : acc_q;
    lim     = (state_q == IDLE) ? len_eff : len_q;
    cnt_inc = (state_q == IDLE) ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
    sum     = {1'b0, base} + {1'b0, ACC_WIDTH'(i_prod_val)};

    if (i_acc_clr) begin
      state_d   = IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      sat_d     = 1'b0;
      out_vld_d = 1'b0;
      out_sat_d = 1'b0;
      drop_d    = 1'b0;
    end else begin
      if (i_prod_valid) begin
        acc_d = sum[ACC_WIDTH-1:0];
        sat_d = (state_q == IDLE) ? 1'b0 : sat_q;
`ifdef MAC_ACC_SAT_EN
        if (sum[ACC_WIDTH] || sat_d) begin
          acc_d = '1;
          sat_d = 1'b1;
        end
`endif
        cnt_d = cnt_inc;
        len_d = lim;
        if (cnt_inc == lim) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end

      if (done) begin
        if (out_vld_q && !accept) begin
          drop_d = 1'b1;
        end else begin
          out_val_d = acc_d;
          out_sat_d = sat_d;
          out_vld_d = 1'b1;
        end
        sat_d = 1'b0;
      end else if (accept) begin
        out_vld_d = 1'b0;
      end
    end
  end

`ifndef MAC_ACC_SAT_EN
  // Without saturation the carry is simply discarded (wrap).
  logic unused_carry;
  assign unused_carry = sum[ACC_WIDTH];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      sat_q     <= 1'b0;
      out_val_q <= '0;
      out_vld_q <= 1'b0;
      out_sat_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sat_q     <= sat_d;
      out_val_q <= out_val_d;
      out_vld_q <= out_vld_d;
      out_sat_q <= out_sat_d;
      drop_q    <= drop_d;
    end
  end

  assign o_acc_val   = out_val_q;
  assign o_acc_valid = out_vld_q;
  assign o_acc_sat   = out_sat_q;
  assign o_acc_busy  = (state_q == ACCUM);
  assign o_acc_drop  = drop_q;

endmodule

// File: tb/tb_mac_acc.sv
// Bench for mac_acc: directed vector table, saturation/reset sequences, randomized run against a list-based model.
module tb_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  len = 8'd1;
  logic        clr = 1'b0;
  logic [31:0] pval = '0;
  logic        pvld = 1'b0;
  logic        rdy = 1'b0;

  logic [39:0] acc_val;
  logic        acc_valid, acc_sat, acc_busy, acc_drop;
  logic [33:0] s_val;
  logic        s_valid, s_sat, s_busy, s_drop;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mac_acc dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_acc_len(len), .i_acc_clr(clr),
    .i_prod_val(pval), .i_prod_valid(pvld),
    .o_acc_val(acc_val), .o_acc_valid(acc_valid), .i_acc_ready(rdy),
    .o_acc_sat(acc_sat), .o_acc_busy(acc_busy), .o_acc_drop(acc_drop)
  );

  mac_acc #(.IN_WIDTH(32), .ACC_WIDTH(34), .CNT_WIDTH(8)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_acc_len(len), .i_acc_clr(clr),
    .i_prod_val(pval), .i_prod_valid(pvld),
    .o_acc_val(s_val), .o_acc_valid(s_valid), .i_acc_ready(rdy),
    .o_acc_sat(s_sat), .o_acc_busy(s_busy), .o_acc_drop(s_drop)
  );

  typedef struct {
    logic [7:0]  len;
    logic        clr;
    logic        vld;
    logic [31:0] val;
    logic        rdy;
    logic        e_valid;
    logic [39:0] e_val;
    logic        e_busy;
    logic        e_drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add_v(input logic [7:0] l, input logic c, input logic v, input logic [31:0] d,
                       input logic r, input logic ev, input logic [39:0] eval,
                       input logic eb, input logic ed);
    vec_t t;
    t.len = l; t.clr = c; t.vld = v; t.val = d; t.rdy = r;
    t.e_valid = ev; t.e_val = eval; t.e_busy = eb; t.e_drop = ed;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: a result is the plain sum of the products collected since the last completion.
  logic [31:0] prods[$];
  int unsigned target = 0;
  logic        m_valid = 1'b0;
  logic [39:0] m_val = '0;
  logic        m_drop = 1'b0;

  task automatic model_step();
    logic        acc_ok;
    logic        complete;
    logic [63:0] total;
    acc_ok = m_valid && rdy;
    complete = 1'b0;
    total = '0;
    if (clr) begin
      prods.delete();
      m_valid = 1'b0;
      m_drop  = 1'b0;
      return;
    end
    if (pvld) begin
      if (prods.size() == 0) target = (len == 0) ? 1 : int'(len);
      prods.push_back(pval);
      if (prods.size() == target) begin
        foreach (prods[k]) total += 64'(prods[k]);
        prods.delete();
        complete = 1'b1;
      end
    end
    if (complete) begin
      if (m_valid && !acc_ok) m_drop = 1'b1;
      else begin
        m_valid = 1'b1;
        m_val   = total[39:0];
      end
    end else if (acc_ok) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic [33:0] exp_s_val;
    logic        exp_s_sat;

    // Basic sum, len=4
    add_v(4,0,1,1,1, 0,0,1,0);
    add_v(4,0,1,2,1, 0,0,1,0);
    add_v(4,0,1,3,1, 0,0,1,0);
    add_v(4,0,1,4,1, 1,10,0,0);
    add_v(4,0,0,0,1, 0,0,0,0);
    // Back-to-back, len=2
    add_v(2,0,1,5,1, 0,0,1,0);
    add_v(2,0,1,6,1, 1,11,0,0);
    add_v(2,0,1,7,1, 0,0,1,0);
    add_v(2,0,1,8,1, 1,15,0,0);
    add_v(2,0,0,0,1, 0,0,0,0);
    // Same with a gap between 7 and 8
    add_v(2,0,1,5,1, 0,0,1,0);
    add_v(2,0,1,6,1, 1,11,0,0);
    add_v(2,0,1,7,1, 0,0,1,0);
    add_v(2,0,0,0,1, 0,0,1,0);
    add_v(2,0,1,8,1, 1,15,0,0);
    add_v(2,0,0,0,1, 0,0,0,0);
    // Backpressure and drop, len=1
    add_v(1,0,1,9,0, 1,9,0,0);
    add_v(1,0,1,3,0, 1,9,0,1);
    add_v(1,0,0,0,0, 1,9,0,1);
    add_v(1,0,0,0,1, 0,0,0,1);
    add_v(1,0,0,0,1, 0,0,0,1);
    add_v(1,0,1,4,0, 1,4,0,1);
    add_v(1,0,1,5,1, 1,5,0,1);
    add_v(1,0,0,0,1, 0,0,0,1);
    // Clear mid-operation
    add_v(4,0,1,1,1, 0,0,1,1);
    add_v(4,0,1,2,1, 0,0,1,1);
    add_v(4,1,1,100,1, 0,0,0,0);
    add_v(1,0,1,7,1, 1,7,0,0);
    add_v(1,0,0,0,1, 0,0,0,0);
    // Length 0 behaves as 1
    add_v(0,0,1,12,1, 1,12,0,0);
    add_v(0,0,0,0,1, 0,0,0,0);

    // Reset state
    #2;
    chk("rst_valid", 64'(acc_valid), 0);
    chk("rst_val",   64'(acc_val), 0);
    chk("rst_busy",  64'(acc_busy), 0);
    chk("rst_drop",  64'(acc_drop), 0);
    chk("rst_sat",   64'(acc_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      len = tbl[i].len; clr = tbl[i].clr; pvld = tbl[i].vld; pval = tbl[i].val; rdy = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 64'(acc_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_busy", i),  64'(acc_busy),  64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_drop", i),  64'(acc_drop),  64'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_sat", i),   64'(acc_sat),   0);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_val", i), 64'(acc_val), 64'(tbl[i].e_val));
    end

    // Randomized run against the model
    for (int n = 0; n < 2000; n++) begin
      len  = 8'($urandom_range(0, 6));
      clr  = ($urandom_range(0, 99) < 2);
      pvld = ($urandom_range(0, 99) < 75);
      pval = $urandom;
      rdy  = ($urandom_range(0, 99) < 60);
      model_step();
      cyc();
      chk("rnd_valid", 64'(acc_valid), 64'(m_valid));
      chk("rnd_busy",  64'(acc_busy),  64'(prods.size() != 0));
      chk("rnd_drop",  64'(acc_drop),  64'(m_drop));
      chk("rnd_sat",   64'(acc_sat),   0);
      if (m_valid) chk("rnd_val", 64'(acc_val), 64'(m_val));
    end

    // Saturation on the 34-bit instance, plain sum on the 40-bit one
    clr = 1'b1; pvld = 1'b0; rdy = 1'b1;
    cyc();
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      len = 8'd5; pvld = 1'b1; pval = 32'hFFFF_FFFF;
      cyc();
    end
    pvld = 1'b0;
`ifdef MAC_ACC_SAT_EN
    exp_s_val = 34'h3_FFFF_FFFF; exp_s_sat = 1'b1;
`else
    exp_s_val = 34'h0_FFFF_FFFB; exp_s_sat = 1'b0;
`endif
    chk("sat_valid", 64'(s_valid), 1);
    chk("sat_val",   64'(s_val), 64'(exp_s_val));
    chk("sat_flag",  64'(s_sat), 64'(exp_s_sat));
    chk("wide_val",  64'(acc_val), 64'h4_FFFF_FFFB);
    chk("wide_sat",  64'(acc_sat), 0);
    cyc();
    chk("sat_accepted", 64'(s_valid), 0);

    // Async reset while accumulating with a result pending
    len = 8'd1; pvld = 1'b1; pval = 32'd8; rdy = 1'b0;
    cyc();
    len = 8'd4; pval = 32'd1;
    cyc();
    chk("pre_rst_busy",  64'(acc_busy), 1);
    chk("pre_rst_valid", 64'(acc_valid), 1);
    pvld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_val",   64'(acc_val), 0);
    chk("arst_valid", 64'(acc_valid), 0);
    chk("arst_busy",  64'(acc_busy), 0);
    chk("arst_drop",  64'(acc_drop), 0);
    chk("arst_sat",   64'(acc_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    len = 8'd1; pvld = 1'b1; pval = 32'd3; rdy = 1'b1;
    cyc();
    chk("post_rst_valid", 64'(acc_valid), 1);
    chk("post_rst_val",   64'(acc_val), 3);
    chk("post_rst_busy",  64'(acc_busy), 0);
    pvld = 1'b0;
    cyc();
    chk("post_rst_done", 64'(acc_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mac_acc.md
# mac_acc

Accumulation stage directly downstream of the pipelined multiplier: it consumes the unsigned product stream (value + valid) and sums a programmed number of consecutive products into a dot-product result. The finished result is presented on a single-entry valid/ready output register. The multiplier has no backpressure, so this block never stalls its input. It reports a dropped result instead.

## Interface
- `IN_WIDTH`, default 32: product width; matches multiplier output width.
- `ACC_WIDTH`, default 40: accumulator and result width; must be ≥ `IN_WIDTH`.
- `CNT_WIDTH`, default 8: width of the length field.
- Reset is asynchronous and active-low.
- `i_clk` in, 1: single clock; all logic is on its rising edge.
- `i_rst_n` in, 1: asynchronous active-low reset.
- `i_acc_len` in, `CNT_WIDTH`: number of products per result; 0 is treated as 1; sampled on the first product of each result.
- `i_acc_clr` in, 1: synchronous abort/clear; highest priority.
- `i_prod_val` in, `IN_WIDTH`: product from the multiplier, unsigned.
- `i_prod_valid` in, 1: product qualifier.
- `o_acc_val` out, `ACC_WIDTH`: result.
- `o_acc_valid` out, 1: result available.
- `i_acc_ready` in, 1: the consumer accepts the result when `o_acc_valid` and `i_acc_ready` are both high.
- `o_acc_sat` out, 1: the current result saturated (only with the saturation macro defined, see Configuration).
- `o_acc_busy` out, 1: FSM is in ACCUM.
- `o_acc_drop` out, 1: sticky; at least one result was discarded.

## Operation
**FSM states**
- IDLE
  - A valid product loads `acc` = zero-extended product.
  - `len` is latched from `i_acc_len` (0 is latched as 1) and `cnt` is set to 1.
  - If `len` = 1, the result completes this cycle and the FSM stays in IDLE.
  - Otherwise the FSM goes to ACCUM.
- ACCUM
  - A valid product sets `acc` += product and increments `cnt`.
  - When `cnt` reaches `len`, the result completes and the FSM returns to IDLE.
  - Cycles with `i_prod_valid` low leave all state unchanged. Gaps in the product stream are legal.

**Result completion**
- The completed sum is written to the output register, `o_acc_valid` is set, and the saturation flag is captured alongside.
- If the output register is occupied and not accepted this cycle, the new result is discarded. `o_acc_val` keeps the old result and `o_acc_drop` is set.
- If the register is accepted in the same cycle a new result completes, the new result overwrites it and `o_acc_valid` stays high.
- An accept with no completion clears `o_acc_valid`.

**Clear (`i_acc_clr`)**
- The FSM goes to IDLE; `acc`, `cnt`, `o_acc_valid`, `o_acc_sat` and `o_acc_drop` are cleared.
- A product presented in the same cycle is discarded.
- `o_acc_val` is not required to change.

**Arithmetic**
- Unsigned.
- Every addition is `ACC_WIDTH`+1 bits wide; overflow handling is set by Configuration.

## Timing
- **Reset values:** `o_acc_val`=0, `o_acc_valid`=0, `o_acc_sat`=0, `o_acc_busy`=0, `o_acc_drop`=0; FSM in IDLE, `acc`=0, `cnt`=0.
- **Async reset mid-operation:** the partial sum is lost and the first product after deassertion starts a new result.
- **Latency:** the result is valid on the cycle after the clock edge that samples the last product.
- **Throughput:** one product per cycle, with no bubble between results. The first product of the next result may immediately follow the last product of the previous one.
- With `len` = 1, every valid product produces one result.
- **Output hold:** `o_acc_val` and `o_acc_sat` are stable while `o_acc_valid`=1 and `i_acc_ready`=0.

## Configuration
- `MAC_ACC_SAT_EN` defined:
  - an addition whose carry out of `ACC_WIDTH` is set clamps `acc` to all-ones and sets an internal sat flag, which stays set until the result completes;
  - the flag is reported on `o_acc_sat` with the result;
  - all later additions into that result keep `acc` at all-ones.
- `MAC_ACC_SAT_EN` not defined:
  - the sum wraps modulo 2^`ACC_WIDTH`;
  - `o_acc_sat` is tied to 0.

## Test plan
All scenarios use `IN_WIDTH`=32 and `ACC_WIDTH`=40 unless stated otherwise.
- **Basic sum:** `len`=4, products 1,2,3,4 on consecutive cycles, ready=1 → `o_acc_val`=10 and `o_acc_valid` high for exactly one cycle, one cycle after the product 4 edge; `busy` high from after the product 1 edge until the product 4 edge.
- **Back-to-back with gap:** `len`=2, products 5,6,7,8 on consecutive cycles → results 11 and 15, two cycles apart. Repeat with one idle cycle between 7 and 8 → 15 arrives one cycle later.
- **Backpressure/drop:** ready=0, `len`=1, products 9 then 3 → `o_acc_val` holds 9, `o_acc_drop`=1. Raise ready → one transfer of 9, then `o_acc_valid`=0. Finally, ready=1 with a new product 5 at the same time as the accept → 5 replaces the accepted result.
- **Saturation** (`ACC_WIDTH`=34, `len`=5, five products of 0xFFFF_FFFF):
  - with `MAC_ACC_SAT_EN` → `o_acc_val`=0x3_FFFF_FFFF, `o_acc_sat`=1;
  - without → `o_acc_val`=0x0_FFFF_FFFB, `o_acc_sat`=0.
- **Clear mid-operation:** `len`=4, products 1,2, then `clr` together with product 100, then `len`=1, product 7 → single result 7 and `o_acc_drop`=0.
- **Async reset:** assert `i_rst_n` low between clock edges while in ACCUM → all outputs 0 immediately. After release, `len`=1, product 3 → result 3.
